spi_flash_reader: RTL and testbench

//  Bus master driving the SPI controller's register port. Issues a serial-flash READ (cmd 0x03 +
//  24-bit address), clocks out N bytes and delivers them as a valid/ready byte stream. Sits

---
 rtl/spi_flash_reader_pkg.sv | 52 +++++
 rtl/spi_flash_reader_bus_master.sv | 91 +++++++++
 rtl/spi_flash_reader.sv | 206 ++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_reader_pkg
//  Description : Shared definitions for the SPI flash reader. Holds the SPI
//                controller register map, the control/status bit positions,
//                the FSM state encodings and a control-word helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_reader_pkg;

    // SPI controller register map
    localparam logic [1:0] c_SPI_REG_DATA  = 2'd0;
    localparam logic [1:0] c_SPI_REG_CTRL  = 2'd1;

    // Control register bits (write) and status register bit (read)
    localparam int         c_CTRL_SS_BIT   = 0;
    localparam int         c_CTRL_RXEN_BIT = 1;
    localparam int         c_STAT_IDLE_BIT = 0;

    // Reader sequencing states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SEL    = 4'd1,
        ST_CMD    = 4'd2,
        ST_DRAIN0 = 4'd3,
        ST_RXEN   = 4'd4,
        ST_DUMMY  = 4'd5,
        ST_RX     = 4'd6,
        ST_OUT    = 4'd7,
        ST_DRAIN1 = 4'd8,
        ST_DESEL  = 4'd9,
        ST_DONE   = 4'd10
    } reader_state_t;

    // Single bus transaction states
    typedef enum logic [1:0] {
        BUS_IDLE    = 2'd0,
        BUS_REQ     = 2'd1,
        BUS_RELEASE = 2'd2
    } bus_state_t;

    // Build a control register write value
    function automatic logic [31:0] ctrl_word(input logic ss, input logic rx_en);
        logic [31:0] w;
        w                  = '0;
        w[c_CTRL_SS_BIT]   = ss;
        w[c_CTRL_RXEN_BIT] = rx_en;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_reader_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_reader_bus_master
//  Description : Runs exactly one SPI register-port transaction per i_go.
//                Drives rw/address/wdata with request high, holds them until
//                i_spi_ready, captures read data on that cycle, drops request
//                the next cycle and only reports o_done once i_spi_ready has
//                returned low, so the next transaction can never overlap.
//  Ports       : i_clock, i_reset      - clock, sync active-high reset
//                i_go/i_rw/i_addr/i_wdata - transaction request (1-cycle go)
//                o_done, o_rdata       - completion pulse, captured read data
//                o_spi_*, i_spi_*      - SPI controller register port
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader_bus_master
    import spi_flash_reader_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_go,
    input  logic        i_rw,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_spi_request,
    output logic        o_spi_rw,
    output logic [1:0]  o_spi_address,
    output logic [31:0] o_spi_wdata,
    input  logic [31:0] i_spi_rdata,
    input  logic        i_spi_ready
);

    bus_state_t  r_state;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_request;
    logic        r_rw;
    logic [1:0]  r_address;
    logic [31:0] r_wdata;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= BUS_IDLE;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_request <= 1'b0;
            r_rw      <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                BUS_IDLE: begin
                    if (i_go) begin
                        r_rw      <= i_rw;
                        r_address <= i_addr;
                        r_wdata   <= i_wdata;
                        r_request <= 1'b1;
                        r_state   <= BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    if (i_spi_ready) begin
                        r_rdata   <= i_spi_rdata;
                        r_request <= 1'b0;
                        r_state   <= BUS_RELEASE;
                    end
                end
                BUS_RELEASE: begin
                    // Completion waits for ready to fall so a follow-on
                    // request cannot be mistaken for acknowledged.
                    if (!i_spi_ready) begin
                        r_done  <= 1'b1;
                        r_state <= BUS_IDLE;
                    end
                end
                default: r_state <= BUS_IDLE;
            endcase
        end
    end

    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
    assign o_spi_request = r_request;
    assign o_spi_rw      = r_rw;
    assign o_spi_address = r_address;
    assign o_spi_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_reader
//  Description : Reads a block from serial flash through the SPI controller
//                register port (READ opcode + 24-bit address, then one dummy
//                TX byte per RX byte) and streams the bytes out with
//                valid/ready flow control.
//  Ports       : i_clock, i_reset         - clock, sync active-high reset
//                i_start, i_flash_addr, i_length - transfer request
//                o_busy, o_done            - transfer status
//                o_data, o_valid, i_ready  - output byte stream
//                o_spi_*, i_spi_*          - SPI controller register port
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int         LEN_WIDTH = 16,
    parameter logic [7:0] READ_CMD  = 8'h03
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [23:0]          i_flash_addr,
    input  logic [LEN_WIDTH-1:0] i_length,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_spi_request,
    output logic                 o_spi_rw,
    output logic [1:0]           o_spi_address,
    output logic [31:0]          o_spi_wdata,
    input  logic [31:0]          i_spi_rdata,
    input  logic                 i_spi_ready
);

    reader_state_t        r_state;
    logic [23:0]          r_addr;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [1:0]           r_cmd_idx;
    logic                 r_issued;
    logic                 r_go;
    logic                 r_rw;
    logic [1:0]           r_bus_addr;
    logic [31:0]          r_bus_wdata;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic [7:0]           r_data;

    logic                 w_bus_done;
    logic [31:0]          w_bus_rdata;
    logic                 w_unused_rdata;
    logic [7:0]           w_cmd_byte;
    logic                 w_op_rw;
    logic [1:0]           w_op_addr;
    logic [31:0]          w_op_wdata;

    assign w_unused_rdata = ^w_bus_rdata[31:8];

    always_comb begin
        w_cmd_byte = READ_CMD;
        case (r_cmd_idx)
            2'd1:    w_cmd_byte = r_addr[23:16];
            2'd2:    w_cmd_byte = r_addr[15:8];
            2'd3:    w_cmd_byte = r_addr[7:0];
            default: w_cmd_byte = READ_CMD;
        endcase
    end

    // Bus operation implied by each bus-phase state
    always_comb begin
        w_op_rw    = 1'b1;
        w_op_addr  = c_SPI_REG_DATA;
        w_op_wdata = '0;
        case (r_state)
            ST_SEL: begin
                w_op_addr  = c_SPI_REG_CTRL;
                w_op_wdata = ctrl_word(1'b1, 1'b0);
            end
            ST_CMD:  w_op_wdata = {24'd0, w_cmd_byte};
            ST_DRAIN0, ST_DRAIN1: begin
                w_op_rw   = 1'b0;
                w_op_addr = c_SPI_REG_CTRL;
            end
            ST_RXEN: begin
                w_op_addr  = c_SPI_REG_CTRL;
                w_op_wdata = ctrl_word(1'b1, 1'b1);
            end
            ST_RX:   w_op_rw = 1'b0;
            ST_DESEL: begin
                w_op_addr  = c_SPI_REG_CTRL;
                w_op_wdata = ctrl_word(1'b0, 1'b0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_cmd_idx   <= '0;
            r_issued    <= 1'b0;
            r_go        <= 1'b0;
            r_rw        <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= i_flash_addr;
                            r_remaining <= i_length;
                            r_busy      <= 1'b1;
                            r_state     <= ST_SEL;
                        end
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        r_valid     <= 1'b0;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        r_state     <= (r_remaining == LEN_WIDTH'(1)) ? ST_DRAIN1 : ST_DUMMY;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_SEL, ST_CMD, ST_DRAIN0, ST_RXEN, ST_DUMMY, ST_RX, ST_DRAIN1, ST_DESEL: begin
                    // Each state issues one transaction, then reacts to its
                    // completion; clearing r_issued re-arms for the next op.
                    if (!r_issued) begin
                        r_go        <= 1'b1;
                        r_rw        <= w_op_rw;
                        r_bus_addr  <= w_op_addr;
                        r_bus_wdata <= w_op_wdata;
                        r_issued    <= 1'b1;
                    end else if (w_bus_done) begin
                        r_issued <= 1'b0;
                        case (r_state)
                            ST_SEL: begin
                                r_cmd_idx <= '0;
                                r_state   <= ST_CMD;
                            end
                            ST_CMD: begin
                                if (r_cmd_idx == 2'd3) r_state <= ST_DRAIN0;
                                r_cmd_idx <= r_cmd_idx + 2'd1;
                            end
                            ST_DRAIN0: if (w_bus_rdata[c_STAT_IDLE_BIT]) r_state <= ST_RXEN;
                            ST_RXEN:   r_state <= ST_DUMMY;
                            ST_DUMMY:  r_state <= ST_RX;
                            ST_RX: begin
                                r_data  <= w_bus_rdata[7:0];
                                r_valid <= 1'b1;
                                r_state <= ST_OUT;
                            end
                            ST_DRAIN1: if (w_bus_rdata[c_STAT_IDLE_BIT]) r_state <= ST_DESEL;
                            ST_DESEL: begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    spi_flash_reader_bus_master u_bus (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_go          (r_go),
        .i_rw          (r_rw),
        .i_addr        (r_bus_addr),
        .i_wdata       (r_bus_wdata),
        .o_done        (w_bus_done),
        .o_rdata       (w_bus_rdata),
        .o_spi_request (o_spi_request),
        .o_spi_rw      (o_spi_rw),
        .o_spi_address (o_spi_address),
        .o_spi_wdata   (o_spi_wdata),
        .i_spi_rdata   (i_spi_rdata),
        .i_spi_ready   (i_spi_ready)
    );

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_flash_reader
//  Description : Self-checking bench for spi_flash_reader. A behavioural SPI
//                controller register port with an attached flash model
//                (flash[a] = a[7:0] ^ 8'hA5) answers the reader's bus cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_ready;
    logic [23:0] i_flash_addr;
    logic [15:0] i_length;
    logic        o_busy, o_done, o_valid;
    logic [7:0]  o_data;
    logic        o_spi_request, o_spi_rw;
    logic [1:0]  o_spi_address;
    logic [31:0] o_spi_wdata;
    logic [31:0] i_spi_rdata;
    logic        i_spi_ready;

    always #5 clk = ~clk;

    spi_flash_reader dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_flash_addr  (i_flash_addr),
        .i_length      (i_length),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_spi_request (o_spi_request),
        .o_spi_rw      (o_spi_rw),
        .o_spi_address (o_spi_address),
        .o_spi_wdata   (o_spi_wdata),
        .i_spi_rdata   (i_spi_rdata),
        .i_spi_ready   (i_spi_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SPI controller + flash model ----------------
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  mosi_log[$];
    logic        m_ss = 1'b0, m_rxen = 1'b0;
    int          m_timer = 0, m_fidx = 0;
    logic [23:0] m_faddr = '0;
    int          status_ones = 0, ss_viol = 0;

    initial begin
        logic [7:0] b, miso;
        logic       idle;
        i_spi_ready = 1'b0;
        i_spi_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (i_reset) begin
                tx_q.delete(); rx_q.delete();
                m_ss = 1'b0; m_rxen = 1'b0; m_timer = 0; m_fidx = 0;
                i_spi_ready = 1'b0;
            end else begin
                // Shifter: one byte every 4 cycles
                if (m_timer > 0) m_timer--;
                else if (tx_q.size() > 0) begin
                    b = tx_q.pop_front();
                    m_timer = 3;
                    mosi_log.push_back(b);
                    if (!m_ss) ss_viol++;
                    miso = 8'hFF;
                    if (m_fidx >= 1 && m_fidx <= 3) m_faddr = {m_faddr[15:0], b};
                    else if (m_fidx >= 4) begin
                        miso = flash_byte(m_faddr);
                        m_faddr = m_faddr + 24'd1;
                    end
                    m_fidx++;
                    if (m_rxen) rx_q.push_back(miso);
                end
                // Register port
                if (i_spi_ready) i_spi_ready = 1'b0;
                else if (o_spi_request) begin
                    if (o_spi_rw) begin
                        if (o_spi_address == 2'd1) begin
                            if (m_ss != o_spi_wdata[0]) m_fidx = 0;
                            m_ss   = o_spi_wdata[0];
                            m_rxen = o_spi_wdata[1];
                        end else tx_q.push_back(o_spi_wdata[7:0]);
                        i_spi_rdata = '0;
                        i_spi_ready = 1'b1;
                    end else if (o_spi_address == 2'd1) begin
                        idle = (tx_q.size() == 0) && (m_timer == 0);
                        if (idle) status_ones++;
                        i_spi_rdata = {31'd0, idle};
                        i_spi_ready = 1'b1;
                    end else if (rx_q.size() > 0) begin
                        i_spi_rdata = {24'd0, rx_q.pop_front()};
                        i_spi_ready = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- Output monitor ----------------
    logic [7:0] stream[$];
    int done_cnt = 0, req_rises = 0, viol_vr = 0, viol_dv = 0, viol_ri = 0;
    logic req_q = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!i_reset) begin
            if (o_valid && i_ready) stream.push_back(o_data);
            if (o_done) done_cnt++;
            if (o_spi_request && !req_q) req_rises++;
            if (o_valid && o_spi_request) viol_vr++;
            if (o_done && o_valid) viol_dv++;
            if (o_spi_request && !o_busy) viol_ri++;
        end
        req_q = o_spi_request;
    end

    // ---------------- Helpers ----------------
    task automatic start_xfer(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        i_start = 1'b1; i_flash_addr = a; i_length = l;
        @(posedge clk); #1;
        i_start = 1'b0; i_flash_addr = 24'hFFFFFF; i_length = 16'hFFFF;
    endtask

    task automatic wait_done(input int budget, output int busy_low);
        int n;
        busy_low = 0;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (o_done) break;
            if (!o_busy) busy_low++;
        end
        if (n >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no o_done within %0d cycles", budget);
        end
    endtask

    task automatic check_stream(input string tag, input logic [23:0] a, input int len);
        int errs;
        errs = 0;
        for (int k = 0; k < stream.size() && k < len; k++)
            if (stream[k] !== flash_byte(a + 24'(k))) errs++;
        check({tag, " byte count"}, stream.size(), len);
        check({tag, " byte errors"}, errs, 0);
    endtask

    task automatic check_mosi(input string tag, input logic [23:0] a, input int len);
        int errs;
        logic [7:0] exp;
        errs = 0;
        for (int k = 0; k < mosi_log.size(); k++) begin
            case (k)
                0:       exp = 8'h03;
                1:       exp = a[23:16];
                2:       exp = a[15:8];
                3:       exp = a[7:0];
                default: exp = 8'h00;
            endcase
            if (mosi_log[k] !== exp) errs++;
        end
        check({tag, " mosi count"}, mosi_log.size(), len + 4);
        check({tag, " mosi errors"}, errs, 0);
    endtask

    task automatic clear_logs();
        stream.delete();
        mosi_log.delete();
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        logic [7:0]  first;
        logic [7:0]  last;
    } vec_t;

    // ---------------- Test sequence ----------------
    initial begin
        vec_t vecs[3];
        int   bl, d0c, r0, unstable, n;
        logic [7:0] d0;

        vecs[0] = '{24'h012345, 16'd4, 8'hE0, 8'hED};
        vecs[1] = '{24'h000000, 16'd2, 8'hA5, 8'hA4};
        vecs[2] = '{24'h0000FE, 16'd3, 8'h5B, 8'hA5};

        i_reset = 1'b1; i_start = 1'b0; i_ready = 1'b1;
        i_flash_addr = '0; i_length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset status", {o_busy, o_done, o_valid, o_spi_request, o_spi_rw, o_spi_address}, 0);
        check("reset data", {o_data, 24'd0}, 0);
        check("reset wdata", o_spi_wdata, 0);
        @(posedge clk); #1 i_reset = 1'b0;

        // Table-driven transfers
        for (int i = 0; i < 3; i++) begin
            clear_logs();
            d0c = done_cnt;
            start_xfer(vecs[i].addr, vecs[i].len);
            wait_done(5000, bl);
            repeat (3) @(negedge clk);
            check_stream($sformatf("vec%0d", i), vecs[i].addr, int'(vecs[i].len));
            check_mosi($sformatf("vec%0d", i), vecs[i].addr, int'(vecs[i].len));
            if (stream.size() == int'(vecs[i].len)) begin
                check($sformatf("vec%0d first", i), stream[0], vecs[i].first);
                check($sformatf("vec%0d last", i), stream[stream.size()-1], vecs[i].last);
            end
            check($sformatf("vec%0d done pulses", i), done_cnt - d0c, 1);
            check($sformatf("vec%0d ss released", i), m_ss, 0);
            check($sformatf("vec%0d busy after", i), o_busy, 0);
        end

        // Zero length: done next cycle, no bus traffic
        clear_logs();
        r0 = req_rises;
        start_xfer(24'h001000, 16'd0);
        check("len0 done", o_done, 1);
        check("len0 busy", o_busy, 0);
        @(posedge clk); #1;
        check("len0 done pulse width", o_done, 0);
        repeat (10) @(negedge clk);
        check("len0 requests", req_rises - r0, 0);
        check("len0 mosi", mosi_log.size(), 0);
        check("len0 ss", m_ss, 0);

        // Backpressure
        clear_logs();
        i_ready = 1'b0;
        start_xfer(24'h000200, 16'd3);
        n = 0;
        while (!o_valid && n < 2000) begin @(negedge clk); n++; end
        check("bp valid seen", o_valid, 1);
        check("bp first byte", o_data, 8'hA5);
        d0 = o_data; r0 = req_rises; unstable = 0;
        repeat (200) begin
            @(negedge clk);
            if (!o_valid || o_data !== d0) unstable++;
        end
        check("bp hold unstable", unstable, 0);
        check("bp requests while held", req_rises - r0, 0);
        @(posedge clk); #1 i_ready = 1'b1;
        wait_done(5000, bl);
        repeat (2) @(negedge clk);
        check_stream("bp", 24'h000200, 3);

        // Restart while busy is ignored
        clear_logs();
        d0c = done_cnt;
        start_xfer(24'h000300, 16'd4);
        repeat (30) @(posedge clk);
        start_xfer(24'h00ABCD, 16'd2);
        wait_done(5000, bl);
        repeat (3) @(negedge clk);
        check_stream("restart", 24'h000300, 4);
        check_mosi("restart", 24'h000300, 4);
        check("restart done pulses", done_cnt - d0c, 1);

        // Reset mid-transfer
        clear_logs();
        start_xfer(24'h000100, 16'd8);
        n = 0;
        while (stream.size() < 2 && n < 2000) begin @(negedge clk); n++; end
        check("rst reached byte 2", stream.size() >= 2, 1);
        @(posedge clk); #1 i_reset = 1'b1;
        @(posedge clk); #1;
        check("midrst status", {o_busy, o_done, o_valid, o_spi_request, o_spi_rw, o_spi_address}, 0);
        check("midrst data", {o_data, 24'd0}, 0);
        check("midrst wdata", o_spi_wdata, 0);
        i_reset = 1'b0;
        d0c = done_cnt;
        repeat (30) @(negedge clk);
        check("midrst no done", done_cnt - d0c, 0);
        clear_logs();
        start_xfer(24'h000000, 16'd2);
        wait_done(5000, bl);
        repeat (2) @(negedge clk);
        check_stream("after rst", 24'h000000, 2);

        // Long transfer
        clear_logs();
        status_ones = 0;
        start_xfer(24'h00FF00, 16'd300);
        wait_done(20000, bl);
        repeat (3) @(negedge clk);
        check("long busy low cycles", bl, 0);
        check_stream("long", 24'h00FF00, 300);
        check("long mosi count", mosi_log.size(), 304);
        check("long idle status reads", status_ones, 2);

        // Protocol invariants over the whole run
        check("valid with request", viol_vr, 0);
        check("done with valid", viol_dv, 0);
        check("request while not busy", viol_ri, 0);
        check("byte shifted with ss off", ss_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
